// File: rtl/eeg_pea_pkg.sv
// Shared types for the PE-array output path: sequencer states
// and an index-width helper used to size PE index fields.
package eeg_pea_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_FIN
    } state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/eeg_rr_arb.sv
// N-way round-robin arbiter: search starts one past the last winner,
// pointer moves to the winner whenever a grant is issued.
module eeg_rr_arb
    import eeg_pea_pkg::*;
#(
    parameter int N  = 16,
    parameter int IW = idx_w(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  i_req,
    input  logic          i_en,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_idx,
    output logic          o_vld
);

    logic [IW-1:0] r_ptr;
    logic [IW:0]   w_sum;

    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_vld = 1'b0;
        w_sum = '0;
        for (int k = 1; k <= N; k++) begin
            w_sum = {1'b0, r_ptr} + (IW+1)'(k);
            if (w_sum >= (IW+1)'(N)) begin
                w_sum = w_sum - (IW+1)'(N);
            end
            if (i_en && !o_vld && i_req[w_sum[IW-1:0]]) begin
                o_gnt[w_sum[IW-1:0]] = 1'b1;
                o_idx = w_sum[IW-1:0];
                o_vld = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= IW'(N-1);
        end else if (o_vld) begin
            r_ptr <= o_idx;
        end
    end

endmodule

// File: rtl/eeg_pea_out_arb.sv
// Merges the PE result streams into the output RAM write port,
// tags each word with its PE index and signals tile completion.
module eeg_pea_out_arb
    import eeg_pea_pkg::*;
#(
    parameter int PE_ROW      = 4,
    parameter int PE_COL      = 4,
    parameter int PE_NUM      = PE_ROW*PE_COL,
    parameter int PE_IW       = idx_w(PE_NUM),
    parameter int DATA_OUT_DW = 8,
    parameter int OMUX_ADD_AW = 8,
    parameter int OADD_AW     = OMUX_ADD_AW+PE_IW,
    parameter int CNT_DW      = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          START,
    input  logic [PE_NUM-1:0]             CFG_PE_MSK,
    output logic                          IS_IDLE,
    output logic                          DONE,
    output logic [CNT_DW-1:0]             BEAT_CNT,
    input  logic [PE_NUM-1:0]             PE_VLD,
    input  logic [PE_NUM-1:0]             PE_LST,
    input  logic [PE_NUM*DATA_OUT_DW-1:0] PE_DAT,
    input  logic [PE_NUM*OMUX_ADD_AW-1:0] PE_ADD,
    output logic [PE_NUM-1:0]             PE_RDY,
    output logic                          ORAM_VLD,
    input  logic                          ORAM_RDY,
    output logic [OADD_AW-1:0]            ORAM_ADD,
    output logic [DATA_OUT_DW-1:0]        ORAM_DAT
);

    state_t r_state;
    state_t w_nxt;

    logic [PE_NUM-1:0]      r_msk;
    logic [PE_NUM-1:0]      r_done;
    logic [CNT_DW-1:0]      r_cnt;
    logic                   r_ovld;
    logic [OADD_AW-1:0]     r_oadd;
    logic [DATA_OUT_DW-1:0] r_odat;

    logic [PE_NUM-1:0]      w_elig;
    logic [PE_NUM-1:0]      w_gnt;
    logic [PE_NUM-1:0]      w_lst_hit;
    logic [PE_IW-1:0]       w_gidx;
    logic                   w_gvld;
    logic                   w_slot_free;
    logic                   w_gen;
    logic                   w_all_done;
    logic                   w_start;
    logic [DATA_OUT_DW-1:0] w_pdat;
    logic [OMUX_ADD_AW-1:0] w_padd;

    assign w_elig      = PE_VLD & r_msk & ~r_done;
    assign w_slot_free = ~r_ovld | ORAM_RDY;
    assign w_gen       = (r_state == S_RUN) & w_slot_free;
    assign w_start     = (r_state == S_IDLE) & START;

    eeg_rr_arb #(
        .N  (PE_NUM),
        .IW (PE_IW)
    ) u_arb (
        .clk   (clk),
        .rst   (rst),
        .i_req (w_elig),
        .i_en  (w_gen),
        .o_gnt (w_gnt),
        .o_idx (w_gidx),
        .o_vld (w_gvld)
    );

    assign PE_RDY    = w_gnt;
    assign w_lst_hit = w_gnt & PE_LST;
    // A same-cycle LST handshake already counts toward completion.
    assign w_all_done = (((r_done | w_lst_hit) & r_msk) == r_msk);

    assign w_pdat = PE_DAT[int'(w_gidx)*DATA_OUT_DW +: DATA_OUT_DW];
    assign w_padd = PE_ADD[int'(w_gidx)*OMUX_ADD_AW +: OMUX_ADD_AW];

    always_comb begin
        w_nxt   = r_state;
        IS_IDLE = 1'b0;
        DONE    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                IS_IDLE = 1'b1;
                if (START) begin
                    w_nxt = (CFG_PE_MSK == '0) ? S_FIN : S_RUN;
                end
            end
            S_RUN: begin
                if (w_all_done) begin
                    w_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_slot_free) begin
                    w_nxt = S_FIN;
                end
            end
            S_FIN: begin
                DONE  = 1'b1;
                w_nxt = S_IDLE;
            end
            default: w_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_msk  <= '0;
            r_done <= '0;
            r_cnt  <= '0;
        end else if (w_start) begin
            r_msk  <= CFG_PE_MSK;
            r_done <= '0;
            r_cnt  <= '0;
        end else if (w_gvld) begin
            r_done <= r_done | w_lst_hit;
            r_cnt  <= r_cnt + CNT_DW'(1);
        end
    end

    // Output register: refilled on grant, held under backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovld <= 1'b0;
            r_oadd <= '0;
            r_odat <= '0;
        end else if (w_gvld) begin
            r_ovld <= 1'b1;
            r_oadd <= {w_gidx, w_padd};
            r_odat <= w_pdat;
        end else if (ORAM_RDY) begin
            r_ovld <= 1'b0;
        end
    end

    assign ORAM_VLD = r_ovld;
    assign ORAM_ADD = r_oadd;
    assign ORAM_DAT = r_odat;
    assign BEAT_CNT = r_cnt;

endmodule

// File: tb/tb_eeg_pea_out_arb.sv
// Directed bench for eeg_pea_out_arb: PE stream model, write log,
// one task per scenario with inline expected-value comparisons.
module tb_eeg_pea_out_arb;

    localparam int N   = 16;
    localparam int DW  = 8;
    localparam int AW  = 8;
    localparam int OAW = 12;
    localparam int CW  = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic            START;
    logic [N-1:0]    CFG_PE_MSK;
    logic            IS_IDLE;
    logic            DONE;
    logic [CW-1:0]   BEAT_CNT;
    logic [N-1:0]    PE_VLD;
    logic [N-1:0]    PE_LST;
    logic [N*DW-1:0] PE_DAT;
    logic [N*AW-1:0] PE_ADD;
    logic [N-1:0]    PE_RDY;
    logic            ORAM_VLD;
    logic            ORAM_RDY;
    logic [OAW-1:0]  ORAM_ADD;
    logic [DW-1:0]   ORAM_DAT;

    eeg_pea_out_arb dut (
        .clk        (clk),
        .rst        (rst),
        .START      (START),
        .CFG_PE_MSK (CFG_PE_MSK),
        .IS_IDLE    (IS_IDLE),
        .DONE       (DONE),
        .BEAT_CNT   (BEAT_CNT),
        .PE_VLD     (PE_VLD),
        .PE_LST     (PE_LST),
        .PE_DAT     (PE_DAT),
        .PE_ADD     (PE_ADD),
        .PE_RDY     (PE_RDY),
        .ORAM_VLD   (ORAM_VLD),
        .ORAM_RDY   (ORAM_RDY),
        .ORAM_ADD   (ORAM_ADD),
        .ORAM_DAT   (ORAM_DAT)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    int          left [N];
    int          seqn [N];
    bit          force_v [N];
    bit          d_rst = 1'b1;
    bit          d_start = 1'b0;
    logic [N-1:0] d_msk = '0;
    int          bp_lo = -1;
    int          bp_hi = -1;
    bit          rdy_low = 1'b0;
    int          cyc = 0;
    int          gq[$];
    logic [19:0] wq[$];
    int          wcyc[$];
    int          done_cnt = 0;
    int          done_cyc = -1;
    int          stab_err = 0;
    int          bp_err = 0;
    int          ill_err = 0;
    bit          rdy4_seen = 1'b0;
    bit          p_vld = 1'b0;
    logic [19:0] p_word = '0;

    function automatic logic [19:0] exp_word(input int pe, input int s);
        return {4'(pe), 8'(s), 8'(pe*16 + s)};
    endfunction

    // One clock: drive at negedge, sample 1 ns later, update PE model.
    task automatic cycle();
        @(negedge clk);
        cyc++;
        rst        = d_rst;
        START      = d_start;
        CFG_PE_MSK = d_msk;
        ORAM_RDY   = !(cyc >= bp_lo && cyc <= bp_hi) && !rdy_low;
        for (int i = 0; i < N; i++) begin
            PE_VLD[i] = (left[i] > 0) || force_v[i];
            PE_LST[i] = (left[i] == 1);
            PE_DAT[i*DW +: DW] = DW'(i*16 + seqn[i]);
            PE_ADD[i*AW +: AW] = AW'(seqn[i]);
        end
        #1;
        if (p_vld && (!ORAM_VLD || {ORAM_ADD, ORAM_DAT} !== p_word))
            stab_err++;
        if (ORAM_VLD && !ORAM_RDY && PE_RDY != '0)
            bp_err++;
        if (!$onehot0(PE_RDY) || (PE_RDY & ~PE_VLD) != '0)
            ill_err++;
        if (PE_RDY[4])
            rdy4_seen = 1'b1;
        if (DONE) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (!rst) begin
            if (ORAM_VLD && ORAM_RDY) begin
                wq.push_back({ORAM_ADD, ORAM_DAT});
                wcyc.push_back(cyc);
            end
            for (int i = 0; i < N; i++) begin
                if (PE_RDY[i]) begin
                    gq.push_back(i);
                    if (left[i] > 0) left[i]--;
                    seqn[i]++;
                end
            end
        end
        p_vld  = ORAM_VLD && !ORAM_RDY && !rst;
        p_word = {ORAM_ADD, ORAM_DAT};
    endtask

    task automatic clear_logs();
        gq.delete();
        wq.delete();
        wcyc.delete();
        done_cnt  = 0;
        done_cyc  = -1;
        stab_err  = 0;
        bp_err    = 0;
        ill_err   = 0;
        rdy4_seen = 1'b0;
        p_vld     = 1'b0;
        bp_lo     = -1;
        bp_hi     = -1;
        rdy_low   = 1'b0;
        for (int i = 0; i < N; i++) begin
            left[i]    = 0;
            seqn[i]    = 0;
            force_v[i] = 1'b0;
        end
    endtask

    task automatic do_reset();
        clear_logs();
        d_rst   = 1'b1;
        d_start = 1'b0;
        repeat (2) cycle();
        d_rst = 1'b0;
        clear_logs();
    endtask

    task automatic start_tile(input logic [N-1:0] m);
        d_start = 1'b1;
        d_msk   = m;
        cycle();
        d_start = 1'b0;
    endtask

    task automatic run_to_done(input int budget);
        for (int k = 0; k < budget && done_cnt == 0; k++) cycle();
        cycle();
        cycle();
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < N; i++) force_v[i] = 1'b1;
        cycle();
        tests++;
        if (IS_IDLE !== 1'b1) begin
            fails++;
            $display("FAIL reset_idle: got %b want 1", IS_IDLE);
        end
        tests++;
        if (DONE !== 1'b0) begin
            fails++;
            $display("FAIL reset_done: got %b want 0", DONE);
        end
        tests++;
        if (BEAT_CNT !== 16'd0) begin
            fails++;
            $display("FAIL reset_beat: got %0d want 0", BEAT_CNT);
        end
        tests++;
        if (PE_RDY !== 16'h0) begin
            fails++;
            $display("FAIL reset_rdy: got %h want 0", PE_RDY);
        end
        tests++;
        if (ORAM_VLD !== 1'b0 || ORAM_ADD !== 12'h0 || ORAM_DAT !== 8'h0) begin
            fails++;
            $display("FAIL reset_oram: got %b/%h/%h want 0/0/0",
                     ORAM_VLD, ORAM_ADD, ORAM_DAT);
        end
    endtask

    task automatic test_single_pe();
        do_reset();
        left[0] = 3;
        start_tile(16'h0001);
        run_to_done(40);
        tests++;
        if (wq.size() != 3) begin
            fails++;
            $display("FAIL single_nwr: got %0d want 3", wq.size());
        end
        for (int k = 0; k < 3; k++) begin
            tests++;
            if (k >= wq.size() || wq[k] !== exp_word(0, k)) begin
                fails++;
                $display("FAIL single_word%0d: got %h want %h", k,
                         (k < wq.size()) ? wq[k] : 20'hx, exp_word(0, k));
            end
        end
        tests++;
        if (wcyc.size() != 3 || wcyc[2] - wcyc[0] != 2) begin
            fails++;
            $display("FAIL single_b2b: got %0d writes not back-to-back want 3",
                     wcyc.size());
        end
        tests++;
        if (done_cnt != 1 || wcyc.size() != 3 || done_cyc != wcyc[2] + 1) begin
            fails++;
            $display("FAIL single_done: got cnt %0d cyc %0d want 1 pulse 1 after last",
                     done_cnt, done_cyc);
        end
        tests++;
        if (BEAT_CNT !== 16'd3) begin
            fails++;
            $display("FAIL single_beat: got %0d want 3", BEAT_CNT);
        end
        tests++;
        if (IS_IDLE !== 1'b1) begin
            fails++;
            $display("FAIL single_idle: got %b want 1", IS_IDLE);
        end
    endtask

    task automatic test_all_pe();
        do_reset();
        for (int i = 0; i < N; i++) left[i] = 2;
        start_tile(16'hFFFF);
        run_to_done(120);
        tests++;
        if (gq.size() != 32) begin
            fails++;
            $display("FAIL all_ngrant: got %0d want 32", gq.size());
        end
        for (int k = 0; k < 32; k++) begin
            tests++;
            if (k >= gq.size() || gq[k] != k % 16) begin
                fails++;
                $display("FAIL all_order%0d: got %0d want %0d", k,
                         (k < gq.size()) ? gq[k] : -1, k % 16);
            end
        end
        tests++;
        if (wq.size() != 32) begin
            fails++;
            $display("FAIL all_nwr: got %0d want 32", wq.size());
        end
        for (int k = 0; k < 32 && k < wq.size(); k++) begin
            tests++;
            if (wq[k] !== exp_word(k % 16, k / 16)) begin
                fails++;
                $display("FAIL all_word%0d: got %h want %h", k, wq[k],
                         exp_word(k % 16, k / 16));
            end
        end
        tests++;
        if (done_cnt != 1 || BEAT_CNT !== 16'd32 || ill_err != 0) begin
            fails++;
            $display("FAIL all_done: got done %0d beat %0d ill %0d want 1/32/0",
                     done_cnt, BEAT_CNT, ill_err);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        left[0] = 4;
        left[1] = 4;
        bp_lo = cyc + 1 + 4;
        bp_hi = bp_lo + 4;
        start_tile(16'h0003);
        run_to_done(60);
        tests++;
        if (stab_err != 0 || bp_err != 0) begin
            fails++;
            $display("FAIL bp_stable: got stab %0d rdy %0d want 0/0",
                     stab_err, bp_err);
        end
        tests++;
        if (wq.size() != 8) begin
            fails++;
            $display("FAIL bp_nwr: got %0d want 8", wq.size());
        end
        for (int k = 0; k < 8 && k < wq.size(); k++) begin
            tests++;
            if (wq[k] !== exp_word(k % 2, k / 2)) begin
                fails++;
                $display("FAIL bp_word%0d: got %h want %h", k, wq[k],
                         exp_word(k % 2, k / 2));
            end
        end
        tests++;
        if (wcyc.size() != 8 || wcyc[7] - wcyc[0] != 12) begin
            fails++;
            $display("FAIL bp_span: got %0d writes want 8 over 12 cycles",
                     wcyc.size());
        end
        tests++;
        if (done_cnt != 1 || BEAT_CNT !== 16'd8) begin
            fails++;
            $display("FAIL bp_done: got done %0d beat %0d want 1/8",
                     done_cnt, BEAT_CNT);
        end
    endtask

    task automatic test_mask();
        do_reset();
        for (int i = 0; i < 4; i++) left[i] = 1;
        force_v[4] = 1'b1;
        start_tile(16'h000F);
        run_to_done(40);
        tests++;
        if (rdy4_seen) begin
            fails++;
            $display("FAIL mask_rdy4: got 1 want 0");
        end
        tests++;
        if (gq.size() != 4 || gq[0] != 0 || gq[1] != 1 || gq[2] != 2 || gq[3] != 3) begin
            fails++;
            $display("FAIL mask_order: got %0d grants want 0,1,2,3", gq.size());
        end
        tests++;
        if (done_cnt != 1 || BEAT_CNT !== 16'd4) begin
            fails++;
            $display("FAIL mask_done: got done %0d beat %0d want 1/4",
                     done_cnt, BEAT_CNT);
        end
        tests++;
        if (IS_IDLE !== 1'b1) begin
            fails++;
            $display("FAIL mask_idle: got %b want 1", IS_IDLE);
        end
    endtask

    task automatic test_lst_continue();
        int exp_g [10] = '{0, 1, 2, 3, 0, 1, 3, 0, 1, 3};
        int s [4] = '{0, 0, 0, 0};
        int n2 = 0;
        do_reset();
        left[0] = 3;
        left[1] = 3;
        left[2] = 1;
        left[3] = 3;
        force_v[2] = 1'b1;
        start_tile(16'h000F);
        run_to_done(60);
        tests++;
        if (gq.size() != 10) begin
            fails++;
            $display("FAIL cont_ngrant: got %0d want 10", gq.size());
        end
        for (int k = 0; k < 10 && k < gq.size() && k < wq.size(); k++) begin
            tests++;
            if (gq[k] != exp_g[k] || wq[k] !== exp_word(exp_g[k], s[exp_g[k]])) begin
                fails++;
                $display("FAIL cont_step%0d: got pe %0d word %h want pe %0d word %h",
                         k, gq[k], wq[k], exp_g[k], exp_word(exp_g[k], s[exp_g[k]]));
            end
            s[exp_g[k]]++;
        end
        foreach (gq[k]) if (gq[k] == 2) n2++;
        tests++;
        if (n2 != 1) begin
            fails++;
            $display("FAIL cont_pe2: got %0d grants want 1", n2);
        end
        tests++;
        if (done_cnt != 1 || wcyc.size() != 10 || done_cyc != wcyc[9] + 1) begin
            fails++;
            $display("FAIL cont_done: got cnt %0d cyc %0d want 1 pulse after last",
                     done_cnt, done_cyc);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        left[0] = 5;
        left[1] = 5;
        start_tile(16'h0003);
        repeat (3) cycle();
        d_start = 1'b1;
        d_msk   = 16'h0000;
        cycle();
        d_start = 1'b0;
        rdy_low = 1'b1;
        cycle();
        tests++;
        if (IS_IDLE !== 1'b0 || BEAT_CNT !== 16'd4 || done_cnt != 0) begin
            fails++;
            $display("FAIL mid_start: got idle %b beat %0d done %0d want 0/4/0",
                     IS_IDLE, BEAT_CNT, done_cnt);
        end
        tests++;
        if (ORAM_VLD !== 1'b1) begin
            fails++;
            $display("FAIL mid_vld: got %b want 1", ORAM_VLD);
        end
        d_rst = 1'b1;
        cycle();
        d_rst = 1'b0;
        cycle();
        tests++;
        if (ORAM_VLD !== 1'b0 || IS_IDLE !== 1'b1 || BEAT_CNT !== 16'd0) begin
            fails++;
            $display("FAIL mid_rst: got vld %b idle %b beat %0d want 0/1/0",
                     ORAM_VLD, IS_IDLE, BEAT_CNT);
        end
        repeat (3) cycle();
        tests++;
        if (done_cnt != 0 || IS_IDLE !== 1'b1) begin
            fails++;
            $display("FAIL mid_nodone: got done %0d idle %b want 0/1",
                     done_cnt, IS_IDLE);
        end
    endtask

    initial begin
        rst        = 1'b1;
        START      = 1'b0;
        CFG_PE_MSK = '0;
        PE_VLD     = '0;
        PE_LST     = '0;
        PE_DAT     = '0;
        PE_ADD     = '0;
        ORAM_RDY   = 1'b1;
        test_reset();
        test_single_pe();
        test_all_pe();
        test_backpressure();
        test_mask();
        test_lst_continue();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish by 200000");
        $fatal(1);
    end

endmodule

// File: doc/eeg_pea_out_arb.md
Name: eeg_pea_out_arb

Overview:
- Round-robin arbiter and sequencer for the result streams of the PE array engine. Each PE of the PE_COL x PE_ROW grid drives one output stream, PE_NUM streams in total.
- Merges all streams into the single write port of the output RAM and tags each word with its PE index.
- Tracks per-PE end-of-tile (LST) and reports tile completion to the layer controller with a done pulse.

Parameters:
- PE_ROW, 4, PE rows in the array
- PE_COL, 4, PE columns in the array
- PE_NUM, PE_ROW*PE_COL, number of output streams; stream index i = col*PE_ROW + row
- PE_IW, $clog2(PE_NUM), PE index width
- DATA_OUT_DW, 8, result word width
- OMUX_ADD_AW, 8, per-PE local address width
- OADD_AW, OMUX_ADD_AW+PE_IW, output RAM address width
- CNT_DW, 16, beat counter width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- START  in  1  pulse: begin a tile
- CFG_PE_MSK  in  PE_NUM  participating PEs; sampled on START
- IS_IDLE  out  1  FSM in IDLE
- DONE  out  1  one-cycle pulse when the tile completes
- BEAT_CNT  out  CNT_DW  words written in the current or last tile
- PE_VLD  in  PE_NUM  per-PE result valid
- PE_LST  in  PE_NUM  per-PE last word of tile
- PE_DAT  in  PE_NUM*DATA_OUT_DW  per-PE result data
- PE_ADD  in  PE_NUM*OMUX_ADD_AW  per-PE local address
- PE_RDY  out  PE_NUM  per-PE ready; one-hot or zero
- ORAM_VLD  out  1  write request
- ORAM_RDY  in  1  write accepted
- ORAM_ADD  out  OADD_AW  {PE index, local address}
- ORAM_DAT  out  DATA_OUT_DW  write data

Behaviour:
- Reset values: IS_IDLE=1, DONE=0, BEAT_CNT=0, PE_RDY=0, ORAM_VLD=0, ORAM_ADD=0, ORAM_DAT=0. The FSM enters IDLE, rr_ptr=PE_NUM-1 and all done flags clear. Reset mid-tile discards the buffered word; no DONE is issued.
- FSM IDLE, RUN, DRAIN, FIN:
  - IDLE to RUN on START. On that cycle: latch msk=CFG_PE_MSK, clear done[], clear BEAT_CNT.
  - START with CFG_PE_MSK==0 goes IDLE to FIN directly.
  - RUN to DRAIN when every msk bit has its done bit set, counting a same-cycle LST handshake.
  - DRAIN to FIN once the output register is empty (ORAM_VLD=0), or is emptying that cycle.
  - FIN lasts 1 cycle with DONE=1, then returns to IDLE.
  - START outside IDLE is ignored.
- Eligibility: elig[i] = PE_VLD[i] & msk[i] & ~done[i]. PEs that are unmasked or already done are never granted; their valid is ignored.
- Grant:
  - Only in RUN, and only when slot_free = ~ORAM_VLD | ORAM_RDY.
  - grant = first eligible index searching rr_ptr+1, rr_ptr+2, ... modulo PE_NUM.
  - PE_RDY = grant, which is combinational from PE_VLD. At most one PE handshakes per cycle.
- On a handshake with PE i:
  - Next cycle: ORAM_VLD=1, ORAM_ADD={i[PE_IW-1:0], PE_ADD[i]}, ORAM_DAT=PE_DAT[i]. Latency is 1 cycle; throughput is 1 word/cycle when ORAM_RDY is held high.
  - rr_ptr <= i.
  - BEAT_CNT increments; it wraps at 2^CNT_DW with no flag.
  - If PE_LST[i], then done[i] <= 1.
- Output register: held stable while ORAM_VLD & ~ORAM_RDY. It clears only on acceptance with no new grant.
- Fairness: with all PEs continuously eligible, every masked PE is granted exactly once per PE_NUM grants.
- Simultaneous events:
  - An LST from the final PE and ORAM acceptance in the same cycle are both honoured.
  - DONE never asserts before the last word is accepted by ORAM.
- IS_IDLE = (state==IDLE), combinational from state.

Decomposition:
- Shared package eeg_pea_pkg: state enum (IDLE/RUN/DRAIN/FIN) and PE index width function.
- Sub-module eeg_rr_arb: parameterized N-way round-robin arbiter with ports req, en, grant one-hot, grant index, pointer update on en. It is reusable for the activation/weight feeders.

Test Plan:
- Reset, then START with MSK=16'h0001. PE0 sends 3 words (ADD 0,1,2, LST on the third) with ORAM_RDY=1. Expect ORAM_ADD 0x000, 0x001, 0x002 on consecutive cycles, DONE 1 cycle after the last write, BEAT_CNT=3.
- MSK=16'hFFFF, all PE_VLD held high, each PE sends 2 words. Expect the grant order 0,1,...,15,0,...,15, 32 writes, DONE once, ORAM_ADD[11:8] matching the grant index.
- Backpressure: ORAM_RDY=0 for 5 cycles mid-stream. ORAM_ADD/DAT stay stable, PE_RDY=0 throughout, and no word is lost or duplicated.
- MSK=16'h000F while PE4 asserts PE_VLD. PE_RDY[4] is never 1. After LST from PEs 0-3: DONE asserts, then IS_IDLE=1.
- PE2 continues PE_VLD after its LST. It is not granted again, the others proceed, and DONE follows the last LST of the remaining PEs.
- rst=1 while ORAM_VLD=1 mid-tile. Next cycle ORAM_VLD=0 and IS_IDLE=1, no DONE. A START issued during RUN is ignored.
